// File: rtl/uart_channel_buffer_pkg.sv
// Shared definitions for the UART channel buffer: TX FSM encodings and FIFO pointer sizing.
package uart_channel_buffer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_channel_buffer_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; push when full and pop when empty are ignored.
module sync_fifo
  import uart_channel_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    count    = wr_ptr_q - rd_ptr_q;
    head     = mem_q[rd_ptr_q[AW-1:0]];
    // Fullness is judged at the start of the cycle, so a same-cycle pop never frees room.
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_channel_buffer.sv
// Per-interface UART byte buffer: RX capture FIFO toward the bus, TX queue feeding the controller.
module uart_channel_buffer
  import uart_channel_buffer_pkg::*;
#(
  parameter int NUM_DATA_BITS = 8,
  parameter int FIFO_DEPTH    = 16,
  parameter int TX_GAP_CYCLES = 0
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          rx_new_data,
  input  logic [NUM_DATA_BITS-1:0]      rx_data,
  input  logic                          tx_write_ready,
  output logic                          tx_start,
  output logic [NUM_DATA_BITS-1:0]      tx_data,
  input  logic                          rd_en,
  output logic [NUM_DATA_BITS-1:0]      rd_data,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_overflow,
  input  logic                          wr_en,
  input  logic [NUM_DATA_BITS-1:0]      wr_data,
  output logic                          tx_full,
  output logic                          tx_busy,
  output logic                          tx_overflow,
  input  logic                          clear_flags
);

  localparam int GW = (TX_GAP_CYCLES > 1) ? $clog2(TX_GAP_CYCLES) : 1;

  logic                         rx_new_q, rx_new_d;
  logic                         rx_ovf_q, rx_ovf_d;
  logic                         tx_ovf_q, tx_ovf_d;
  logic [2:0]                   state_q, state_d;
  logic [GW-1:0]                gap_q, gap_d;
  logic [NUM_DATA_BITS-1:0]     tx_data_q, tx_data_d;
  logic                         rx_push, rx_full, tx_pop, tx_empty;
  logic [NUM_DATA_BITS-1:0]     tx_head;
  logic [$clog2(FIFO_DEPTH):0]  tx_count;

  assign rx_new_d = rx_new_data;
  assign rx_push  = rx_new_data && !rx_new_q;

  sync_fifo #(.WIDTH(NUM_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(sys_clk), .rst(rst), .push(rx_push), .pop(rd_en), .wdata(rx_data),
    .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rd_data)
  );

  sync_fifo #(.WIDTH(NUM_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(sys_clk), .rst(rst), .push(wr_en), .pop(tx_pop), .wdata(wr_data),
    .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
  );

  // A fresh overflow in the same cycle as clear_flags wins.
  always_comb begin
    rx_ovf_d = clear_flags ? 1'b0 : rx_ovf_q;
    tx_ovf_d = clear_flags ? 1'b0 : tx_ovf_q;
    if (rx_push && rx_full) rx_ovf_d = 1'b1;
    if (wr_en && tx_full)   tx_ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    case (state_q)
      ST_IDLE: if (!tx_empty && tx_write_ready) begin
        tx_pop    = 1'b1;
        tx_data_d = tx_head;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_write_ready) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_write_ready) begin
        // Loaded with N-1 so GAP occupies exactly TX_GAP_CYCLES cycles.
        if (TX_GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = GW'(TX_GAP_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: if (gap_q == '0) state_d = ST_IDLE;
              else             gap_d   = gap_q - 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_new_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      state_q   <= ST_IDLE;
      gap_q     <= '0;
      tx_data_q <= '0;
    end else begin
      rx_new_q  <= rx_new_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
      state_q   <= state_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_start    = (state_q == ST_ISSUE);
  assign tx_data     = tx_data_q;
  assign tx_busy     = (state_q != ST_IDLE) || (tx_count != '0);
  assign rx_overflow = rx_ovf_q;
  assign tx_overflow = tx_ovf_q;

endmodule

// File: tb/tb_uart_channel_buffer.sv
// Scoreboard bench: DUT a (no TX gap) exercises RX and TX, DUT g checks the 3-cycle TX gap and queue overflow.
module tb_uart_channel_buffer;

  localparam int DEPTH = 4;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       rst = 1'b1;
  logic       rx_new_data = 1'b0, rd_en = 1'b0, clear_flags = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_write_ready_a = 1'b1, wr_en_a = 1'b0;
  logic [7:0] wr_data_a = 8'h00;
  logic       tx_write_ready_g = 1'b1, wr_en_g = 1'b0;
  logic [7:0] wr_data_g = 8'h00;

  logic       tx_start_a, tx_full_a, tx_busy_a, tx_overflow_a;
  logic [7:0] tx_data_a, rd_data;
  logic       rx_empty, rx_overflow;
  logic [2:0] rx_count;
  logic       tx_start_g, tx_full_g, tx_busy_g, tx_overflow_g;
  logic [7:0] tx_data_g, g_rd_data;
  logic       g_rx_empty, g_rx_overflow;
  logic [2:0] g_rx_count;

  uart_channel_buffer #(.NUM_DATA_BITS(8), .FIFO_DEPTH(DEPTH), .TX_GAP_CYCLES(0)) dut_a (
    .sys_clk(sys_clk), .rst(rst), .rx_new_data(rx_new_data), .rx_data(rx_data),
    .tx_write_ready(tx_write_ready_a), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .wr_en(wr_en_a), .wr_data(wr_data_a), .tx_full(tx_full_a),
    .tx_busy(tx_busy_a), .tx_overflow(tx_overflow_a), .clear_flags(clear_flags)
  );

  uart_channel_buffer #(.NUM_DATA_BITS(8), .FIFO_DEPTH(DEPTH), .TX_GAP_CYCLES(3)) dut_g (
    .sys_clk(sys_clk), .rst(rst), .rx_new_data(1'b0), .rx_data(8'h00),
    .tx_write_ready(tx_write_ready_g), .tx_start(tx_start_g), .tx_data(tx_data_g),
    .rd_en(1'b0), .rd_data(g_rd_data), .rx_empty(g_rx_empty), .rx_count(g_rx_count),
    .rx_overflow(g_rx_overflow), .wr_en(wr_en_g), .wr_data(wr_data_g), .tx_full(tx_full_g),
    .tx_busy(tx_busy_g), .tx_overflow(tx_overflow_g), .clear_flags(clear_flags)
  );

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] exp_rx[$], exp_tx_a[$], exp_tx_g[$], got_a[$], got_g[$];
  int drv_a = 0, drv_g = 0, nstart_a = 0, nstart_g = 0, dbl_a = 0, dbl_g = 0;
  int first_cyc_a = 0, rise_cyc_a = 0, rise_cyc_g = 0, r2s_a = 0, r2s_g = 0;
  logic prev_a = 1'b0, prev_g = 1'b0;

  // One clock: sample outputs on the falling edge, then advance the controller models after the rising edge.
  // Controller model: ready drops the cycle after a start is seen and rises 20 cycles later.
  task automatic tick();
    logic sa, sg;
    @(negedge sys_clk);
    cyc++;
    sa = tx_start_a;
    sg = tx_start_g;
    if (sa === 1'b1) begin
      got_a.push_back(tx_data_a); nstart_a++;
      if (nstart_a == 1) first_cyc_a = cyc;
      r2s_a = cyc - rise_cyc_a;
      if (prev_a === 1'b1) dbl_a++;
    end
    if (sg === 1'b1) begin
      got_g.push_back(tx_data_g); nstart_g++;
      r2s_g = cyc - rise_cyc_g;
      if (prev_g === 1'b1) dbl_g++;
    end
    prev_a = sa;
    prev_g = sg;
    @(posedge sys_clk); #1;
    if (drv_a > 0) begin drv_a--; if (drv_a == 0) begin tx_write_ready_a = 1'b1; rise_cyc_a = cyc; end end
    if (sa === 1'b1) begin tx_write_ready_a = 1'b0; drv_a = 20; end
    if (drv_g > 0) begin drv_g--; if (drv_g == 0) begin tx_write_ready_g = 1'b1; rise_cyc_g = cyc; end end
    if (sg === 1'b1) begin tx_write_ready_g = 1'b0; drv_g = 20; end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_new_data = 1'b1;
    if (exp_rx.size() < DEPTH) exp_rx.push_back(b);
    tick();
    rx_new_data = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({rx_empty, rx_count, rx_overflow, rd_en} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_rx got empty=%b count=%0d ovf=%b exp 1 0 0", rx_empty, rx_count, rx_overflow);
    end
    checks++;
    if ({tx_full_a, tx_start_a, tx_data_a, tx_busy_a, tx_overflow_a} !== 12'h000) begin
      errors++; $display("FAIL reset_tx got full=%b start=%b data=%h busy=%b ovf=%b exp all 0",
                         tx_full_a, tx_start_a, tx_data_a, tx_busy_a, tx_overflow_a);
    end
  endtask

  task automatic test_rx();
    logic [7:0] e;
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    checks++;
    if (rx_count !== 3'd3) begin errors++; $display("FAIL rx_count got %0d exp 3", rx_count); end
    for (int i = 0; i < 3; i++) begin
      e = exp_rx.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("FAIL rx_head[%0d] got %h exp %h", i, rd_data, e); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_empty got %b exp 1", rx_empty); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] e;
    for (int i = 0; i < 5; i++) rx_byte(8'hA0 + 8'(i));
    checks++;
    if ({rx_count, rx_overflow} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL rx_ovf_fill got count=%0d ovf=%b exp 4 1", rx_count, rx_overflow);
    end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rx_ovf_clear got %b exp 0", rx_overflow); end
    // full at cycle start: new byte dropped even though a pop happens in the same cycle
    e = exp_rx.pop_front();
    checks++;
    if (rd_data !== e) begin errors++; $display("FAIL rx_head_full got %h exp %h", rd_data, e); end
    rx_data = 8'hB0; rx_new_data = 1'b1; rd_en = 1'b1;
    tick();
    rx_new_data = 1'b0; rd_en = 1'b0;
    tick();
    checks++;
    if ({rx_count, rx_overflow} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL rx_push_pop_full got count=%0d ovf=%b exp 3 1", rx_count, rx_overflow);
    end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    rx_byte(8'hB1);
    // overflow and clear in the same cycle: flag must stay set
    rx_data = 8'hB2; rx_new_data = 1'b1; clear_flags = 1'b1;
    tick();
    rx_new_data = 1'b0; clear_flags = 1'b0;
    tick();
    checks++;
    if (rx_overflow !== 1'b1) begin errors++; $display("FAIL rx_ovf_vs_clear got %b exp 1", rx_overflow); end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (rx_overflow !== 1'b0) begin errors++; $display("FAIL rx_ovf_clear2 got %b exp 0", rx_overflow); end
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      checks++;
      if (rd_data !== e) begin errors++; $display("FAIL rx_drain got %h exp %h", rd_data, e); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    checks++;
    if ({rx_empty, rx_count} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL rx_drain_empty got empty=%b count=%0d exp 1 0", rx_empty, rx_count);
    end
  endtask

  task automatic test_rx_level();
    rx_data = 8'h5A; rx_new_data = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rx_new_data = 1'b0;
    tick();
    checks++;
    if ({rx_count, rd_data} !== {3'd1, 8'h5A}) begin
      errors++; $display("FAIL rx_level got count=%0d data=%h exp 1 5a", rx_count, rd_data);
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic test_tx();
    int wr_cyc, early, k;
    logic [7:0] e, g;
    nstart_a = 0; dbl_a = 0; early = 0;
    got_a.delete();
    wr_data_a = 8'h41; wr_en_a = 1'b1; wr_cyc = cyc + 1; exp_tx_a.push_back(8'h41);
    tick();
    wr_data_a = 8'h42; exp_tx_a.push_back(8'h42);
    tick();
    wr_en_a = 1'b0;
    checks++;
    if (tx_busy_a !== 1'b1) begin errors++; $display("FAIL tx_busy_set got %b exp 1", tx_busy_a); end
    k = 0;
    while (!(nstart_a >= 2 && drv_a == 0 && tx_busy_a === 1'b0) && k < 300) begin
      tick(); k++;
      if (drv_a > 0 && tx_busy_a !== 1'b1) early++;
    end
    checks++;
    if (k >= 300) begin errors++; $display("FAIL tx_timeout got starts=%0d exp 2 within 300 cycles", nstart_a); end
    checks++;
    if (nstart_a !== 2 || dbl_a !== 0) begin
      errors++; $display("FAIL tx_pulses got starts=%0d double=%0d exp 2 0", nstart_a, dbl_a);
    end
    checks++;
    if (first_cyc_a - wr_cyc !== 2) begin
      errors++; $display("FAIL tx_latency got %0d exp 2", first_cyc_a - wr_cyc);
    end
    // ready sampled one edge after rising, IDLE pops on the next, start visible after that: 3 ticks
    checks++;
    if (r2s_a !== 3) begin errors++; $display("FAIL tx_ready_to_start got %0d exp 3", r2s_a); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL tx_busy_early got %0d idle cycles exp 0", early); end
    while (got_a.size() > 0 && exp_tx_a.size() > 0) begin
      g = got_a.pop_front(); e = exp_tx_a.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL tx_data got %h exp %h", g, e); end
    end
    checks++;
    if (tx_data_a !== 8'h42) begin errors++; $display("FAIL tx_data_hold got %h exp 42", tx_data_a); end
  endtask

  task automatic test_tx_gap();
    int k;
    logic [7:0] e, g;
    nstart_g = 0; dbl_g = 0;
    got_g.delete();
    wr_en_g = 1'b1;
    wr_data_g = 8'h61; exp_tx_g.push_back(8'h61); tick();
    wr_data_g = 8'h62; exp_tx_g.push_back(8'h62); tick();
    wr_en_g = 1'b0;
    k = 0;
    while (!(nstart_g >= 2 && drv_g == 0 && tx_busy_g === 1'b0) && k < 300) begin tick(); k++; end
    checks++;
    if (k >= 300 || nstart_g !== 2 || dbl_g !== 0) begin
      errors++; $display("FAIL gap_pulses got starts=%0d double=%0d exp 2 0", nstart_g, dbl_g);
    end
    // same path as without a gap plus three GAP cycles
    checks++;
    if (r2s_g !== 6) begin errors++; $display("FAIL gap_ready_to_start got %0d exp 6", r2s_g); end
    // hold the controller busy so the queue can fill
    tx_write_ready_g = 1'b0;
    wr_en_g = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data_g = 8'h70 + 8'(i);
      if (i < DEPTH) exp_tx_g.push_back(wr_data_g);
      tick();
    end
    wr_en_g = 1'b0;
    checks++;
    if ({tx_full_g, tx_overflow_g} !== 2'b11) begin
      errors++; $display("FAIL tx_overflow got full=%b ovf=%b exp 1 1", tx_full_g, tx_overflow_g);
    end
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (tx_overflow_g !== 1'b0) begin errors++; $display("FAIL tx_ovf_clear got %b exp 0", tx_overflow_g); end
    tx_write_ready_g = 1'b1;
    k = 0;
    while (!(nstart_g >= 6 && drv_g == 0 && tx_busy_g === 1'b0) && k < 1000) begin tick(); k++; end
    checks++;
    if (k >= 1000 || nstart_g !== 6 || dbl_g !== 0) begin
      errors++; $display("FAIL gap_drain got starts=%0d double=%0d exp 6 0", nstart_g, dbl_g);
    end
    while (got_g.size() > 0 && exp_tx_g.size() > 0) begin
      g = got_g.pop_front(); e = exp_tx_g.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL gap_data got %h exp %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    int n0, k;
    got_a.delete(); exp_tx_a.delete(); exp_rx.delete();
    n0 = nstart_a;
    wr_en_a = 1'b1;
    for (int i = 0; i < 3; i++) begin wr_data_a = 8'h81 + 8'(i); tick(); end
    wr_en_a = 1'b0;
    rx_byte(8'h99);
    k = 0;
    while (nstart_a == n0 && k < 20) begin tick(); k++; end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (nstart_a !== n0 + 1 || drv_a == 0 || rx_count !== 3'd1) begin
      errors++; $display("FAIL rst_setup got starts=%0d rxcount=%0d exp %0d 1", nstart_a - n0, rx_count, 1);
    end
    n0 = nstart_a;
    rst = 1'b1;
    tick();
    rst = 1'b0; drv_a = 0; tx_write_ready_a = 1'b1;
    tick();
    checks++;
    if (nstart_a !== n0) begin errors++; $display("FAIL rst_no_start got %0d starts exp 0", nstart_a - n0); end
    checks++;
    if ({rx_count, rx_empty, tx_busy_a, tx_full_a, tx_start_a} !== {3'd0, 1'b1, 3'b000}) begin
      errors++; $display("FAIL rst_state got rxcount=%0d empty=%b busy=%b full=%b start=%b exp 0 1 0 0 0",
                         rx_count, rx_empty, tx_busy_a, tx_full_a, tx_start_a);
    end
    for (int i = 0; i < 60; i++) tick();
    checks++;
    if (nstart_a !== n0) begin errors++; $display("FAIL rst_after got %0d starts exp 0", nstart_a - n0); end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_rx_overflow();
    test_rx_level();
    test_tx();
    test_tx_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
